// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache, one 32-bit word per line, byte 0 in bits [31:24].
// Read hits are combinational; misses and stores stall through a req/ack memory transaction. Optional DCACHE_STATS_EN adds hit/miss/write counters.
module dcache_ctrl #(
  parameter int LINES       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic        core_re,
  input  logic        core_we,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wr_cnt,
`endif
  output logic        mem_err
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [7:0]         tmo_q, tmo_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic               line_we;
  logic [31:0]        line_wdata;

  logic [IDX-1:0]     core_idx, req_idx;
  logic [TAG_W-1:0]   core_tag, req_tag;
  logic               hit, req_hit;

  assign core_idx = core_addr[2+IDX-1:2];
  assign core_tag = core_addr[31:2+IDX];
  assign req_idx  = mem_addr_q[2+IDX-1:2];
  assign req_tag  = mem_addr_q[31:2+IDX];
  assign hit      = valid_q[core_idx] && (tag_mem[core_idx] == core_tag);
  assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    valid_d     = valid_q;
    line_we     = 1'b0;
    line_wdata  = mem_rdata;
    case (state_q)
      IDLE: begin
        tmo_d = 8'd0;
        if (core_we) begin
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = core_addr & ~32'h3;
          mem_wdata_d = core_wdata;
        end else if (core_re && !hit) begin
          state_d    = RD_MISS;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = core_addr & ~32'h3;
        end
      end
      RD_MISS, WR_THRU: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          tmo_d     = 8'd0;
          if (state_q == RD_MISS) begin
            line_we          = 1'b1;
            valid_d[req_idx] = 1'b1;
            rdata_d          = mem_rdata;
          end else if (req_hit) begin
            // write-hit update only; store misses never allocate
            line_we    = 1'b1;
            line_wdata = mem_wdata_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          rdata_d   = 32'h0;
          tmo_d     = 8'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (state_q == IDLE) begin
      if (core_we) begin
        if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
      end else if (core_re && hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else if (core_re) begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wr_cnt   = wr_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      tmo_q       <= 8'd0;
      valid_q     <= '0;
`ifdef DCACHE_STATS_EN
      hit_cnt_q   <= 32'h0;
      miss_cnt_q  <= 32'h0;
      wr_cnt_q    <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
`ifdef DCACHE_STATS_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
`endif
    end
  end

  // Tag/data arrays need no reset: valid_q guards every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= line_wdata;
    end
  end

  assign core_stall = !rst && ((state_q == RD_MISS) || (state_q == WR_THRU) ||
                               ((state_q == IDLE) && (core_we || (core_re && !hit))));
  assign core_rdata = ((state_q == IDLE) && core_re && hit) ? data_mem[core_idx] : rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with LINES=16, MEM_TIMEOUT=4; the bench plays the backing memory.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_re, core_we, core_stall;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int          a_stall, a_reqs;
  logic        a_saw, a_we, a_dreq, a_done;
  logic [31:0] a_rdata, a_addr, a_wdata;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_re(core_re), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef DCACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wr_cnt(wr_cnt),
`endif
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One core access; ack_at = index of the mem_req cycle that gets the ack (-1: never).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd);
    core_addr = addr; core_we = we; core_re = !we; core_wdata = wd;
    a_stall = 0; a_reqs = 0; a_saw = 0; a_we = 0; a_dreq = 0; a_done = 0;
    a_rdata = 32'h0; a_addr = 32'h0; a_wdata = 32'h0;
    for (int i = 0; i < 40 && !a_done; i++) begin
      #1;
      if (!core_stall) begin
        a_done  = 1'b1;
        a_rdata = core_rdata;
        a_dreq  = mem_req;
      end else begin
        a_stall++;
        if (mem_req) begin
          a_saw = 1'b1; a_addr = mem_addr; a_we = mem_we; a_wdata = mem_wdata;
          if (a_reqs == ack_at) begin
            mem_ack = 1'b1;
            mem_rdata = rd;
          end
          a_reqs++;
        end
      end
      tick();
      mem_ack = 1'b0;
    end
    core_re = 1'b0; core_we = 1'b0;
    chk("access_done_within_bound", a_done, 1);
  endtask

  initial begin
    rst = 1'b1; core_addr = 32'h0; core_re = 1'b0; core_we = 1'b0;
    core_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_mem_err", mem_err, 0);
    tick();
    rst = 1'b0;

    // cold read, ack three cycles after mem_req rises
    access(1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    chk("cold_stall", a_stall, 5);
    chk("cold_rdata", a_rdata, 32'hDEADBEEF);
    chk("cold_addr", a_addr, 32'h40);
    chk("cold_we", a_we, 0);
    chk("cold_req_dropped", a_dreq, 0);
    access(1'b0, 32'h40, 32'h0, 0, 32'h0);
    chk("rehit_stall", a_stall, 0);
    chk("rehit_rdata", a_rdata, 32'hDEADBEEF);
    chk("rehit_noreq", a_saw, 0);

    // write-hit update, ack in first request cycle
    access(1'b1, 32'h40, 32'h12345678, 0, 32'h0);
    chk("wr_stall", a_stall, 2);
    chk("wr_we", a_we, 1);
    chk("wr_wdata", a_wdata, 32'h12345678);
    chk("wr_addr", a_addr, 32'h40);
    access(1'b0, 32'h40, 32'h0, 0, 32'h0);
    chk("wrhit_stall", a_stall, 0);
    chk("wrhit_rdata", a_rdata, 32'h12345678);
    chk("wrhit_noreq", a_saw, 0);

    // write miss does not allocate or disturb the aliased line
    access(1'b1, 32'h80, 32'hAABBCCDD, 1, 32'h0);
    chk("wrmiss_stall", a_stall, 3);
    access(1'b0, 32'h40, 32'h0, 0, 32'h0);
    chk("wrmiss_keep_rdata", a_rdata, 32'h12345678);
    chk("wrmiss_keep_noreq", a_saw, 0);
    access(1'b0, 32'h80, 32'h0, 0, 32'h55667788);
    chk("rd80_req", a_saw, 1);
    chk("rd80_addr", a_addr, 32'h80);
    chk("rd80_stall", a_stall, 2);
    chk("rd80_rdata", a_rdata, 32'h55667788);

    // alias eviction: 0x40 was evicted by 0x80
    access(1'b0, 32'h40, 32'h0, 0, 32'h0BADF00D);
    chk("alias40_req", a_saw, 1);
    chk("alias40_rdata", a_rdata, 32'h0BADF00D);
    access(1'b0, 32'h80, 32'h0, 0, 32'h11112222);
    chk("alias80_req", a_saw, 1);

    // a second index, filled then hit
    access(1'b0, 32'h44, 32'h0, 2, 32'hCAFEF00D);
    chk("rd44_stall", a_stall, 4);
    chk("rd44_rdata", a_rdata, 32'hCAFEF00D);
    access(1'b0, 32'h44, 32'h0, 0, 32'h0);
    chk("hit44_noreq", a_saw, 0);
    chk("hit44_rdata", a_rdata, 32'hCAFEF00D);

    // timeout with no ack
    access(1'b0, 32'h100, 32'h0, -1, 32'h0);
    chk("tmo_req_cycles", a_reqs, 4);
    chk("tmo_stall", a_stall, 5);
    chk("tmo_rdata", a_rdata, 32'h0);
    chk("tmo_req_dropped", a_dreq, 0);
    chk("tmo_err", mem_err, 1);
    access(1'b0, 32'h80, 32'h0, 0, 32'h0);
    chk("tmo_line_kept_noreq", a_saw, 0);
    chk("tmo_line_kept_rdata", a_rdata, 32'h11112222);
    chk("tmo_err_sticky", mem_err, 1);

    // reset in the middle of a miss
    core_addr = 32'h48; core_re = 1'b1;
    tick();
    #1;
    chk("rstmid_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_req_drop", mem_req, 0);
    chk("rstmid_stall_drop", core_stall, 0);
    tick();
    rst = 1'b0; core_re = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_no_req", mem_req, 0);
    chk("late_ack_no_stall", core_stall, 0);
    chk("rst_clears_err", mem_err, 0);
    tick();
    access(1'b0, 32'h44, 32'h0, 0, 32'h77778888);
    chk("post_rst_miss", a_saw, 1);
    chk("post_rst_rdata", a_rdata, 32'h77778888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
